cmp_seq_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands using a single shared comp_2bit slice, one 2-bit digit pair per cycle, MSB pair first. It accepts operand pairs through a valid/ready handshake, steps the slice across the digit pairs, and returns a registered gt/lt/eq result with a valid/ready handshake. It sits between a producer of compare requests and any consumer of magnitude-compare results, where area matters more than latency.

---
 rtl/cmp_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cmp_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_ctrl.sv
// Serial magnitude comparator: one shared 2-bit compare slice is stepped MSB pair first
// over captured operands, with valid/ready handshakes on the operand and result sides.
module cmp_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH/2)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    cycles,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready/out_valid/busy are flops that only track the state, never the peer's inputs.

  localparam int NP = WIDTH/2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NP-1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_t;

  // The one compare slice; called from a single always_comb so it maps to one instance.
  function automatic cmp_t comp_2bit(input logic [1:0] x, input logic [1:0] y);
    cmp_t r;
    logic hi_eq;
    hi_eq = ~(x[1] ^ y[1]);
    r.gt  = (x[1] & ~y[1]) | (hi_eq & x[0] & ~y[0]);
    r.lt  = (~x[1] & y[1]) | (hi_eq & ~x[0] & y[0]);
    r.eq  = hi_eq & ~(x[0] ^ y[0]);
    return r;
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             diff_seen;
  logic             diff_gt;

  logic [1:0]       a_dig;
  logic [1:0]       b_dig;
  cmp_t             slice;
  logic             first_diff;
  logic             run_done;
  logic [CW-1:0]    cnt_nxt;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;

  always_comb begin
    a_dig      = 2'(a_q >> {idx, 1'b0});
    b_dig      = 2'(b_q >> {idx, 1'b0});
    slice      = comp_2bit(a_dig, b_dig);
    first_diff = !diff_seen && !slice.eq;
    run_done   = (idx == '0) || ((EARLY_EXIT != 0) && first_diff);
    cnt_nxt    = cnt + CNT_ONE;
    // The first difference from the MSB wins; later pairs cannot override it.
    res_gt     = diff_seen ? diff_gt  : slice.gt;
    res_lt     = diff_seen ? !diff_gt : slice.lt;
    res_eq     = !diff_seen && slice.eq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      cnt       <= '0;
      diff_seen <= 1'b0;
      diff_gt   <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            idx       <= IDX_TOP;
            cnt       <= '0;
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
            state     <= RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt_nxt;
          if (first_diff) begin
            diff_seen <= 1'b1;
            diff_gt   <= slice.gt;
          end
          if (run_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            gt        <= res_gt;
            lt        <= res_lt;
            eq        <= res_eq;
            cycles    <= cnt_nxt;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Local invariants of the result and handshake flags.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> $onehot({gt, lt, eq}));
  a_clear: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> ({gt, lt, eq} == 3'b000));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable({gt, lt, eq, cycles})));
  a_flags: assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready == (state == IDLE)) && (out_valid == (state == DONE)) && (busy == !in_ready));

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed plus randomized bench for cmp_seq_ctrl; one instance with early exit, one without,
// both checked against a prefix-comparison reference model.
module tb_cmp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] in_valid_v = '0;
  logic [1:0] in_ready_v;
  logic [1:0] out_valid_v;
  logic [1:0] out_ready_v = '0;
  logic [1:0] gt_v, lt_v, eq_v, busy_v;
  logic [2:0] cycles_v [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .cycles(cycles_v[0]), .busy(busy_v[0])
  );

  cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .cycles(cycles_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result is plain unsigned magnitude; with early exit the cost is the length of the
  // shortest MSB-aligned 2-bit-digit prefix on which the operands disagree.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv, input bit ee,
                                output int n, output bit g, output bit l, output bit e);
    g = av > bv;
    l = av < bv;
    e = av == bv;
    n = 4;
    if (ee && !e) begin
      n = 0;
      for (int k = 1; k <= 4; k++)
        if (n == 0 && (av >> (8 - 2*k)) != (bv >> (8 - 2*k))) n = k;
    end
  endfunction

  task automatic chk_reset_vals(input int sel, input string tag);
    chk({tag, "_in_ready"}, in_ready_v[sel], 1);
    chk({tag, "_out_valid"}, out_valid_v[sel], 0);
    chk({tag, "_gtlteq"}, {gt_v[sel], lt_v[sel], eq_v[sel]}, 0);
    chk({tag, "_cycles"}, cycles_v[sel], 0);
    chk({tag, "_busy"}, busy_v[sel], 0);
  endtask

  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input int stall);
    int n_exp;
    int lat;
    bit egt, elt, eeq;
    model(av, bv, sel == 0, n_exp, egt, elt, eeq);
    @(negedge clk);
    chk("idle_in_ready", in_ready_v[sel], 1);
    chk("idle_busy", busy_v[sel], 0);
    a = av;
    b = bv;
    in_valid_v[sel] = 1'b1;
    out_ready_v[sel] = 1'b0;
    @(negedge clk);
    in_valid_v[sel] = 1'b0;
    a = ~av;
    b = 8'($urandom);
    lat = 0;
    while (out_valid_v[sel] !== 1'b1 && lat < 16) begin
      chk("run_in_ready", in_ready_v[sel], 0);
      chk("run_busy", busy_v[sel], 1);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n_exp);
    for (int i = 0; i <= stall; i++) begin
      chk("done_out_valid", out_valid_v[sel], 1);
      chk("done_gtlteq", {gt_v[sel], lt_v[sel], eq_v[sel]}, {egt, elt, eeq});
      chk("done_cycles", cycles_v[sel], n_exp);
      chk("done_in_ready", in_ready_v[sel], 0);
      chk("done_busy", busy_v[sel], 1);
      if (i < stall) begin
        a = 8'($urandom);
        b = 8'($urandom);
        in_valid_v[sel] = 1'b1;
        @(negedge clk);
      end
    end
    in_valid_v[sel] = 1'b0;
    out_ready_v[sel] = 1'b1;
    @(negedge clk);
    out_ready_v[sel] = 1'b0;
    chk("post_out_valid", out_valid_v[sel], 0);
    chk("post_in_ready", in_ready_v[sel], 1);
    chk("post_gtlteq", {gt_v[sel], lt_v[sel], eq_v[sel]}, 0);
    chk("post_busy", busy_v[sel], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    // Clock/reset
    repeat (3) @(negedge clk);
    chk_reset_vals(0, "rst_ee");
    chk_reset_vals(1, "rst_full");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed magnitude cases
    run_op(0, 8'hA5, 8'hA5, 0);
    run_op(0, 8'h80, 8'h7F, 1);
    run_op(0, 8'h12, 8'h13, 0);
    run_op(1, 8'h80, 8'h7F, 0);
    run_op(1, 8'h12, 8'h13, 2);

    // Backpressure with new operands offered throughout, then the next pair goes in
    run_op(0, 8'h40, 8'h3F, 5);
    run_op(0, 8'h3C, 8'hC3, 0);

    // Asynchronous reset during the second RUN cycle
    @(negedge clk);
    a = 8'h00;
    b = 8'hFF;
    in_valid_v[1] = 1'b1;
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(1, "midrun");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("after_rst_out_valid", out_valid_v[1], 0);
      chk("after_rst_in_ready", in_ready_v[1], 1);
    end

    // Randomized back-to-back traffic with result stalls
    for (int i = 0; i < 28; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (8'h03 << (2 * $urandom_range(0, 3)));
        default: rb = 8'($urandom);
      endcase
      run_op((i < 20) ? 0 : 1, ra, rb, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
